fb_read_arbiter: RTL
====================

# fb_read_arbiter

Round-robin arbiter that shares one framebuffer read port (EBR/SPRAM, fixed read latency) between the three panel scan drivers. Each driver issues single-byte read requests for its 112×3-byte panel slice; the arbiter grants at most one per cycle, drives the memory port, and returns the data to the issuing driver. It sits between the `matrix` instances and the framebuffer memory in `chip`.

## Interface
- `NUM_REQ`, 3: number of requesters (1..8).
- `ADDR_W`, 10: framebuffer byte address width; covers 3×336 bytes.
- `DATA_W`, 8: read data width.
- `RD_LAT`, 1: memory read latency in cycles (1..4).
- `BURST_LEN`, 4: maximum back-to-back beats per grant; used only with `FB_ARB_BURST_EN`.

- `clk`  in  1  system clock (48 MHz HFOSC).
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_REQ  read request per requester.
- `addr`  in  NUM_REQ*ADDR_W  packed request addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- `gnt`  out  NUM_REQ  one-hot grant; the beat is accepted when `req[i] & gnt[i]`.
- `rvalid`  out  NUM_REQ  one-hot read-data valid, tagged to the issuing requester.
- `rdata`  out  DATA_W  read data, shared by all requesters; qualified by `rvalid`.
- `mem_en`  out  1  memory read enable.
- `mem_addr`  out  ADDR_W  memory read address.
- `mem_rdata`  in  DATA_W  memory read data, valid RD_LAT cycles after `mem_en`.

## Operation
- `gnt` is combinational from `req` and the registered priority pointer `ptr`. Scan starts at `ptr` and wraps modulo NUM_REQ; the first asserted `req` wins. While `rst` is low, `gnt` is 0.
- Requesters hold `req` and `addr` stable until granted. A requester may drop `req` before it is granted; nothing is issued.
- `mem_en = |gnt`. `mem_addr` = addr of the granted requester; it is 0 when there is no grant.
- After a single-beat grant to requester i, `ptr` becomes (i+1) mod NUM_REQ. Wrap: a grant to NUM_REQ-1 sets `ptr` to 0. With no grant, `ptr` holds.
- Tag pipeline: a one-hot owner register chain of depth RD_LAT+1 records the grant. At the end of the chain the arbiter registers `rdata <= mem_rdata` and drives `rvalid` as the delayed one-hot.
- `rdata` holds its last value when `rvalid` is 0.
- No address range check; addresses pass through unchanged.
- NUM_REQ=1: `gnt = req`.
- Reset values: `ptr`=0, `gnt`=0, `rvalid`=0, `rdata`=0, `mem_en`=0, `mem_addr`=0, tag chain cleared.
- Reset mid-operation discards in-flight reads: no `rvalid` appears after `rst` deasserts for beats accepted before reset.

## Timing
- Beat accepted at cycle T: `mem_rdata` is valid at T+RD_LAT, and `rdata`/`rvalid` are valid at T+RD_LAT+1.
- Throughput is one beat per cycle, fully pipelined. Requesters may have multiple beats in flight.
- `rvalid` order per requester equals issue order.
- Each requester waits at most NUM_REQ-1 cycles for a grant (single-beat mode), or (NUM_REQ-1)×BURST_LEN cycles (burst mode).

## Configuration
- `FB_ARB_BURST_EN` defined:
  - A granted requester keeps `gnt` on consecutive cycles while its `req` stays high, up to BURST_LEN beats.
  - `ptr` advances past it when `req` drops or the beat counter reaches BURST_LEN, whichever comes first.
  - The beat counter resets to 0 when `ptr` moves and on reset.
- `FB_ARB_BURST_EN` not defined:
  - Every grant is a single beat, followed by rotation.
  - The beat counter logic is absent.

## Structure
- Package `fb_arb_pkg` holds:
  - `FB_BYTES_PER_PANEL` = 336.
  - Defaults for NUM_REQ, ADDR_W, DATA_W.
  - Typedef `req_id_t` (one-hot, NUM_REQ bits).
- Sub-module `rr_pick`: combinational rotate-priority-select. Inputs `req` and `ptr`; outputs a one-hot winner and its index. The pointer/burst state and the tag pipeline stay in `fb_read_arbiter`.

## Test plan
- Reset: hold `rst` low with all `req`=1 → `gnt`=0, `mem_en`=0, `rvalid`=0. Release → first grant goes to requester 0.
- Fairness: all three `req` held high for 9 cycles, burst off → `gnt` sequence 001,010,100 repeating; each requester gets 3 beats.
- Latency/tagging: RD_LAT=2, requester 1 reads addr 0x150 at T, memory model returns 0xA5 → `rvalid`=010 and `rdata`=0xA5 at T+3.
- Wrap/idle: only requester 2 requests, then only requester 0 → `ptr` wraps 2→0 and both are granted on the first cycle of their request.
- Burst (`FB_ARB_BURST_EN`, BURST_LEN=4): requesters 0 and 1 both high → grants 0,0,0,0,1,1,1,1. Requester 0 dropping `req` after 2 beats → grant passes to 1 on the next cycle.
- Reset mid-flight: accept a beat, assert `rst` one cycle later → no `rvalid` after reset release; `ptr`=0.

Source files
------------

// File: rtl/fb_read_arbiter_pkg.sv
// Shared constants and types for the framebuffer read arbiter.
package fb_arb_pkg;

   localparam int FB_BYTES_PER_PANEL = 336;

   localparam int NUM_REQ_DEF = 3;
   localparam int ADDR_W_DEF  = 10;
   localparam int DATA_W_DEF  = 8;

   // One-hot requester identifier for the default build.
   typedef logic [NUM_REQ_DEF-1:0] req_id_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fb_read_arbiter_if.sv
// Requester and memory-side bundle of the framebuffer read arbiter.
//
// Handshake: a requester raises req[i] with addr[i] and holds both until the
// cycle where req[i] & gnt[i]; that cycle is the accepted beat. There is no
// backpressure on the return path: rvalid[i] is a single-cycle pulse that
// qualifies the shared rdata bus, and the memory returns mem_rdata exactly
// RD_LAT cycles after mem_en.
interface fb_read_arbiter_if #(
   parameter int NUM_REQ = fb_arb_pkg::NUM_REQ_DEF,
   parameter int ADDR_W  = fb_arb_pkg::ADDR_W_DEF,
   parameter int DATA_W  = fb_arb_pkg::DATA_W_DEF
);
   import fb_arb_pkg::*;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rvalid;
   logic [DATA_W-1:0]         rdata;
   logic                      mem_en;
   logic [ADDR_W-1:0]         mem_addr;
   logic [DATA_W-1:0]         mem_rdata;

   // Requesters plus the memory model.
   modport master (
      output req, addr, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_addr
   );

   // The arbiter.
   modport slave (
      input  req, addr, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_addr
   );

endinterface

// File: rtl/fb_read_arbiter_rr_pick.sv
// Rotate-priority select: scan starts at ptr, wraps modulo NUM_REQ, and the
// first asserted request wins. Purely combinational.
module rr_pick #(
   parameter int NUM_REQ = fb_arb_pkg::NUM_REQ_DEF,
   parameter int PTR_W   = fb_arb_pkg::ptr_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] win,
   output logic [PTR_W-1:0]   win_idx,
   output logic               win_any
);
   import fb_arb_pkg::*;

   logic [PTR_W-1:0] idx;

   // Walk the requesters from ptr onwards and latch the first hit.
   always_comb begin
      win     = '0;
      win_idx = '0;
      win_any = 1'b0;
      idx     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
         if (!win_any && req[idx]) begin
            win[idx] = 1'b1;
            win_idx  = idx;
            win_any  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fb_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency framebuffer read port between
// the panel scan drivers. Grants are combinational from req and the priority
// pointer; a one-hot tag chain carries each grant to the returning data.
// Optional feature macro: FB_ARB_BURST_EN (keep a grant up to BURST_LEN beats).
module fb_read_arbiter
#(
   parameter int NUM_REQ   = fb_arb_pkg::NUM_REQ_DEF,
   parameter int ADDR_W    = fb_arb_pkg::ADDR_W_DEF,
   parameter int DATA_W    = fb_arb_pkg::DATA_W_DEF,
   parameter int RD_LAT    = 1,
   parameter int BURST_LEN = 4,
   localparam int PTR_W    = fb_arb_pkg::ptr_width(NUM_REQ)
) (
   input  logic                  clk,
   input  logic                  rst,
   fb_read_arbiter_if.slave      bus,
   output logic [PTR_W-1:0]      dbg_ptr
);
   import fb_arb_pkg::*;

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [NUM_REQ-1:0] win;
   logic [PTR_W-1:0]   win_idx;
   logic               win_any;
   logic [NUM_REQ-1:0] gnt;
   logic               gnt_any;
   logic [ADDR_W-1:0]  mem_addr;

   logic [NUM_REQ-1:0] tag_q [RD_LAT];
   logic [NUM_REQ-1:0] tag_d [RD_LAT];
   logic [NUM_REQ-1:0] rvalid_q, rvalid_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   // Next requester index after i, wrapping to 0 after the last one.
   function automatic logic [PTR_W-1:0] step(input logic [PTR_W-1:0] i);
      if (int'(i) >= NUM_REQ - 1) return '0;
      return i + 1'b1;
   endfunction

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req     (bus.req),
      .ptr     (ptr_q),
      .win     (win),
      .win_idx (win_idx),
      .win_any (win_any)
   );

   // Grant and memory address; everything is forced idle while in reset.
   always_comb begin
      gnt      = '0;
      mem_addr = '0;
      if (rst && win_any) begin
         gnt = win;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (win[i]) mem_addr = bus.addr[i*ADDR_W +: ADDR_W];
         end
      end
   end

   assign gnt_any      = |gnt;
   assign bus.gnt      = gnt;
   assign bus.mem_en   = gnt_any;
   assign bus.mem_addr = mem_addr;
   assign bus.rvalid   = rvalid_q;
   assign bus.rdata    = rdata_q;
   assign dbg_ptr      = ptr_q;

`ifdef FB_ARB_BURST_EN
   localparam int CNT_W = $clog2(BURST_LEN + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] beats;

   // Burst pointer: ptr parks on the holder until its req drops or it has
   // taken BURST_LEN beats; a grant elsewhere starts a fresh burst there.
   always_comb begin
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      beats = '0;
      if (gnt_any) begin
         beats = (win_idx == ptr_q) ? cnt_q + 1'b1 : CNT_W'(1);
         if (beats >= CNT_W'(BURST_LEN)) begin
            ptr_d = step(win_idx);
            cnt_d = '0;
         end else begin
            ptr_d = win_idx;
            cnt_d = beats;
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Beat counter register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end
`else
   // Single-beat pointer: rotate past every granted requester.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_any) ptr_d = step(win_idx);
   end
`endif

   // Tag chain and return-data capture at the end of the chain.
   always_comb begin
      tag_d[0] = gnt;
      for (int k = 1; k < RD_LAT; k++) tag_d[k] = tag_q[k-1];
      rvalid_d = tag_q[RD_LAT-1];
      rdata_d  = (|tag_q[RD_LAT-1]) ? bus.mem_rdata : rdata_q;
   end

   // Pointer, tag chain and return registers; reset discards in-flight reads.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q    <= '0;
         for (int k = 0; k < RD_LAT; k++) tag_q[k] <= '0;
         rvalid_q <= '0;
         rdata_q  <= '0;
      end else begin
         ptr_q    <= ptr_d;
         for (int k = 0; k < RD_LAT; k++) tag_q[k] <= tag_d[k];
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
      end
   end

endmodule
